// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back path.
//   REG_PC    : selector of r15 (PC), never written through this path
//   reg_idx_t : register selector
//   wb_src_t  : write-back requester identity
//   wb_cmd_t  : registered write command payload (selector + data)
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = 4;
  localparam int unsigned NUM_REGS = 15;
  localparam int unsigned CNT_W    = 2;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam reg_idx_t REG_PC = 4'hF;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_t;

  typedef struct packed {
    reg_idx_t          sel;
    logic [DATA_W-1:0] data;
  } wb_cmd_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with an internal last-grant pointer.
//   clk, rst : clock, asynchronous active-high reset
//   req[1:0] : requests
//   gnt[1:0] : one-hot grant (combinational)
// The pointer records which requester was granted last and advances only when
// a grant is issued. After reset it points at requester 0, so requester 1 wins
// the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q;

  // Grant the sole requester, or on a tie the one not granted last.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Last-grant pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b0;
    end else if (|gnt) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler for the 15-entry register file.
//   clk, rst                    : clock, asynchronous active-high reset
//   alu_valid/reg/data, ready   : ALU write-back request port
//   mem_valid/reg/data, ready   : memory write-back request port
//   reserve_valid, reserve_reg  : decode claims a destination register
//   src1_sel, src2_sel, hazard  : decode source selectors and RAW stall
//   regwBoolean, rwselector,
//   rwdata                      : registered register-file write command
//   busy_mask                   : per-register pending-write flags
//   err_pc_write, err_count     : sticky error flags
module regfile_wb_scheduler
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  input  logic [REG_AW-1:0]   alu_reg,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [REG_AW-1:0]   mem_reg,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ready,
  input  logic                reserve_valid,
  input  logic [REG_AW-1:0]   reserve_reg,
  input  logic [REG_AW-1:0]   src1_sel,
  input  logic [REG_AW-1:0]   src2_sel,
  output logic                hazard,
  output logic                regwBoolean,
  output logic [REG_AW-1:0]   rwselector,
  output logic [DATA_W-1:0]   rwdata,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                err_pc_write,
  output logic                err_count
);

  logic [1:0]                gnt;
  wb_src_t                   win_src;
  wb_cmd_t                   win_cmd;
  wb_cmd_t                   cmd_q;
  logic                      xfer;
  logic                      xfer_pc;
  cnt_t [NUM_REGS-1:0]       cnt_q;
  cnt_t [NUM_REGS-1:0]       cnt_d;
  logic                      cnt_err;
  logic [NUM_REGS-1:0]       inc_vec;
  logic [NUM_REGS-1:0]       dec_vec;
  logic [(2**REG_AW)-1:0]    busy_ext;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({mem_valid, alu_valid}),
    .gnt (gnt)
  );

  // Ready is forced low while reset is held so nothing is accepted.
  assign alu_ready = gnt[0] & ~rst;
  assign mem_ready = gnt[1] & ~rst;
  assign xfer      = alu_ready | mem_ready;

  // Grant mux.
  always_comb begin
    win_src = mem_ready ? WB_MEM : WB_ALU;
    win_cmd = (win_src == WB_MEM) ? '{sel: mem_reg, data: mem_data}
                                  : '{sel: alu_reg, data: alu_data};
  end

  // A write-back to the PC is accepted but dropped.
  assign xfer_pc = xfer && (win_cmd.sel == REG_PC);

  // Registered write command; selector and data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwBoolean <= 1'b0;
      cmd_q       <= '0;
    end else begin
      regwBoolean <= xfer && !xfer_pc;
      if (xfer && !xfer_pc) begin
        cmd_q <= win_cmd;
      end
    end
  end

  assign rwselector = cmd_q.sel;
  assign rwdata     = cmd_q.data;

  // Per-register reserve (increment) and write-back (decrement) strobes.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      inc_vec[i] = reserve_valid && (reserve_reg == reg_idx_t'(i));
      dec_vec[i] = xfer && (win_cmd.sel == reg_idx_t'(i));
    end
  end

  // Counter next state: saturate at both ends and flag the attempt.
  always_comb begin
    cnt_d   = cnt_q;
    cnt_err = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (inc_vec[i] && !dec_vec[i]) begin
        if (cnt_q[i] == '1) begin
          cnt_err = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + cnt_t'(1);
        end
      end else if (dec_vec[i] && !inc_vec[i]) begin
        if (cnt_q[i] == '0) begin
          cnt_err = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - cnt_t'(1);
        end
      end
    end
  end

  // Scoreboard counters and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      err_pc_write <= 1'b0;
      err_count    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      err_pc_write <= err_pc_write | xfer_pc;
      err_count    <= err_count | cnt_err;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      busy_mask[i] = (cnt_q[i] != '0);
    end
  end

  // Padded so a PC selector indexes a constant-zero slot.
  assign busy_ext = {1'b0, busy_mask};

  assign hazard = ((src1_sel != REG_PC) && busy_ext[src1_sel]) ||
                  ((src2_sel != REG_PC) && busy_ext[src2_sel]);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [3:0]  alu_reg = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [3:0]  mem_reg = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic        reserve_valid = 1'b0;
  logic [3:0]  reserve_reg = '0;
  logic [3:0]  src1_sel = '0;
  logic [3:0]  src2_sel = '0;
  logic        hazard;
  logic        regwBoolean;
  logic [3:0]  rwselector;
  logic [31:0] rwdata;
  logic [14:0] busy_mask;
  logic        err_pc_write;
  logic        err_count;

  regfile_wb_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid     (alu_valid),
    .alu_reg       (alu_reg),
    .alu_data      (alu_data),
    .alu_ready     (alu_ready),
    .mem_valid     (mem_valid),
    .mem_reg       (mem_reg),
    .mem_data      (mem_data),
    .mem_ready     (mem_ready),
    .reserve_valid (reserve_valid),
    .reserve_reg   (reserve_reg),
    .src1_sel      (src1_sel),
    .src2_sel      (src2_sel),
    .hazard        (hazard),
    .regwBoolean   (regwBoolean),
    .rwselector    (rwselector),
    .rwdata        (rwdata),
    .busy_mask     (busy_mask),
    .err_pc_write  (err_pc_write),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [3:0]  ar;
    logic [31:0] ad;
    logic        mv;
    logic [3:0]  mr;
    logic [31:0] md;
    logic        rv;
    logic [3:0]  rr;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic        exp_ar;
    logic        exp_mr;
    logic        exp_hz;
  } vec_t;

  typedef struct {
    logic        regw;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [14:0] busy;
    logic        epc;
    logic        ecnt;
  } exp_t;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  // Reference model state.
  logic        ptr_m;
  int          cnt_m[16];
  logic        regw_m;
  logic [3:0]  sel_m;
  logic [31:0] data_m;
  logic        epc_m;
  logic        ecnt_m;

  vec_t vecs[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [3:0] ar, input logic [31:0] ad,
                              input logic mv, input logic [3:0] mr, input logic [31:0] md,
                              input logic rv, input logic [3:0] rr,
                              input logic [3:0] s1, input logic [3:0] s2,
                              input logic ear, input logic emr, input logic ehz);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad;
    v.mv = mv; v.mr = mr; v.md = md;
    v.rv = rv; v.rr = rr; v.s1 = s1; v.s2 = s2;
    v.exp_ar = ear; v.exp_mr = emr; v.exp_hz = ehz;
    return v;
  endfunction

  function automatic logic [14:0] model_busy();
    logic [14:0] b;
    for (int i = 0; i < 15; i++) b[i] = (cnt_m[i] != 0);
    return b;
  endfunction

  task automatic model_reset();
    ptr_m = 1'b0;
    for (int i = 0; i < 16; i++) cnt_m[i] = 0;
    regw_m = 1'b0; sel_m = '0; data_m = '0;
    epc_m = 1'b0; ecnt_m = 1'b0;
    sb.delete();
  endtask

  // One cycle: drive at negedge, check combinational outputs, push expected
  // registered state, then compare after the posedge.
  task automatic step(input vec_t v, input bit use_tbl);
    logic ag, mg, hz, xf, inc, dec;
    logic [3:0] ws;
    logic [31:0] wd;
    exp_t e, got;
    @(negedge clk);
    alu_valid = v.av; alu_reg = v.ar; alu_data = v.ad;
    mem_valid = v.mv; mem_reg = v.mr; mem_data = v.md;
    reserve_valid = v.rv; reserve_reg = v.rr;
    src1_sel = v.s1; src2_sel = v.s2;
    #1;
    if (v.av && v.mv) begin
      mg = (ptr_m == 1'b0);
      ag = !mg;
    end else begin
      ag = v.av;
      mg = v.mv;
    end
    hz = (v.s1 != 4'hF && cnt_m[v.s1] != 0) || (v.s2 != 4'hF && cnt_m[v.s2] != 0);
    if (use_tbl) begin
      chk("tbl_alu_ready", 32'(alu_ready), 32'(v.exp_ar));
      chk("tbl_mem_ready", 32'(mem_ready), 32'(v.exp_mr));
      chk("tbl_hazard", 32'(hazard), 32'(v.exp_hz));
    end
    chk("alu_ready", 32'(alu_ready), 32'(ag));
    chk("mem_ready", 32'(mem_ready), 32'(mg));
    chk("hazard", 32'(hazard), 32'(hz));
    xf = ag | mg;
    ws = mg ? v.mr : v.ar;
    wd = mg ? v.md : v.ad;
    if (xf && ws != 4'hF) begin
      regw_m = 1'b1; sel_m = ws; data_m = wd;
    end else begin
      regw_m = 1'b0;
    end
    if (xf && ws == 4'hF) epc_m = 1'b1;
    for (int i = 0; i < 15; i++) begin
      inc = v.rv && (v.rr == 4'(i));
      dec = xf && (ws == 4'(i));
      if (inc && !dec) begin
        if (cnt_m[i] == 3) ecnt_m = 1'b1; else cnt_m[i]++;
      end else if (dec && !inc) begin
        if (cnt_m[i] == 0) ecnt_m = 1'b1; else cnt_m[i]--;
      end
    end
    if (xf) ptr_m = mg;
    e.regw = regw_m; e.sel = sel_m; e.data = data_m;
    e.busy = model_busy(); e.epc = epc_m; e.ecnt = ecnt_m;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("regwBoolean", 32'(regwBoolean), 32'(got.regw));
    chk("rwselector", 32'(rwselector), 32'(got.sel));
    chk("rwdata", rwdata, got.data);
    chk("busy_mask", 32'(busy_mask), 32'(got.busy));
    chk("err_pc_write", 32'(err_pc_write), 32'(got.epc));
    chk("err_count", 32'(err_count), 32'(got.ecnt));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_regw"}, 32'(regwBoolean), 32'd0);
    chk({tag, "_sel"}, 32'(rwselector), 32'd0);
    chk({tag, "_data"}, rwdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy_mask), 32'd0);
    chk({tag, "_hazard"}, 32'(hazard), 32'd0);
    chk({tag, "_alu_ready"}, 32'(alu_ready), 32'd0);
    chk({tag, "_mem_ready"}, 32'(mem_ready), 32'd0);
    chk({tag, "_err_pc"}, 32'(err_pc_write), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_count), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alu_valid = 1'b1; mem_valid = 1'b1;
    alu_reg = 4'd1; mem_reg = 4'd2;
    reserve_valid = 1'b0; src1_sel = 4'd0; src2_sel = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    alu_valid = 1'b0; mem_valid = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vecs[0]  = mk(1, 3, 32'h0000_1234, 0, 0, 0,            1, 3, 0, 0,   1, 0, 0);
    vecs[1]  = mk(1, 1, 32'h1111_0001, 1, 2, 32'h2222_0001, 1, 2, 0, 0,  0, 1, 0);
    vecs[2]  = mk(1, 1, 32'h1111_0002, 1, 2, 32'h2222_0002, 1, 1, 0, 0,  1, 0, 0);
    vecs[3]  = mk(1, 1, 32'h1111_0003, 1, 2, 32'h2222_0003, 1, 2, 0, 0,  0, 1, 0);
    vecs[4]  = mk(0, 0, 0,             0, 0, 0,            1, 5, 5, 15,  0, 0, 0);
    vecs[5]  = mk(0, 0, 0,             0, 0, 0,            1, 5, 5, 15,  0, 0, 1);
    vecs[6]  = mk(1, 5, 32'h0000_0055, 0, 0, 0,            0, 0, 5, 15,  1, 0, 1);
    vecs[7]  = mk(1, 5, 32'h0000_0056, 0, 0, 0,            0, 0, 5, 15,  1, 0, 1);
    vecs[8]  = mk(0, 0, 0,             0, 0, 0,            0, 0, 5, 15,  0, 0, 0);
    vecs[9]  = mk(0, 0, 0,             1, 15, 32'hDEAD_BEEF, 0, 0, 0, 15, 0, 1, 0);
    vecs[10] = mk(0, 0, 0,             0, 0, 0,            0, 0, 0, 15,  0, 0, 0);
    vecs[11] = mk(0, 0, 0,             0, 0, 0,            1, 7, 0, 15,  0, 0, 0);
    vecs[12] = mk(0, 0, 0,             0, 0, 0,            1, 7, 0, 15,  0, 0, 0);
    vecs[13] = mk(0, 0, 0,             0, 0, 0,            1, 7, 0, 15,  0, 0, 0);
    vecs[14] = mk(0, 0, 0,             0, 0, 0,            1, 7, 0, 15,  0, 0, 0);
    vecs[15] = mk(0, 0, 0,             0, 0, 0,            0, 0, 7, 15,  0, 0, 1);
    vecs[16] = mk(1, 7, 32'h0000_0077, 1, 4, 32'h0000_0044, 0, 0, 7, 15, 1, 0, 1);
    vecs[17] = mk(0, 0, 0,             1, 4, 32'h0000_0044, 0, 0, 7, 15, 0, 1, 1);
    vecs[18] = mk(0, 0, 0,             0, 0, 0,            0, 0, 4, 15,  0, 0, 0);

    do_reset();
    for (int i = 0; i < 19; i++) step(vecs[i], 1'b1);

    // Directed results of the table run.
    chk("final_err_pc_write", 32'(err_pc_write), 32'd1);
    chk("final_err_count", 32'(err_count), 32'd1);
    chk("final_busy_r7", 32'(busy_mask), 32'h0000_0080);

    // Mid-cycle reset with r0 and r5 busy and a write to r0 being granted.
    do_reset();
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 15, 0, 0, 0), 1'b0);
    step(mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 15, 0, 0, 1), 1'b0);
    chk("pre_rst_busy", 32'(busy_mask), 32'h0000_0021);
    @(negedge clk);
    alu_valid = 1'b1; alu_reg = 4'd0; alu_data = 32'hCAFE_F00D;
    reserve_valid = 1'b0; src1_sel = 4'd5; src2_sel = 4'd0;
    #1;
    chk("pre_rst_alu_ready", 32'(alu_ready), 32'd1);
    chk("pre_rst_hazard", 32'(hazard), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    chk("midrst_edge_regw", 32'(regwBoolean), 32'd0);
    @(negedge clk);
    alu_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("post_rst_regw", 32'(regwBoolean), 32'd0);
    chk("post_rst_sel", 32'(rwselector), 32'd0);
    chk("post_rst_data", rwdata, 32'd0);
    chk("post_rst_busy", 32'(busy_mask), 32'd0);

    // After reset the pointer is ALU again, so MEM wins a fresh tie.
    v = mk(1, 9, 32'h0000_0009, 1, 10, 32'h0000_000A, 1, 10, 0, 15, 0, 1, 0);
    step(v, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler for the 15-entry register file. It arbitrates the single write port between the ALU and memory write-back requesters and drives the registered write command. It also keeps a per-register pending-write scoreboard, so decode can stall on read-after-write hazards. It sits between the execute/memory stages and the register file; r15 (PC) is never written.

## Interface
- DATA_W, 32: write data width
- REG_AW, 4: register selector width
- NUM_REGS, 15: writable registers r0..r14
- CNT_W, 2: pending-write counter width per register
- clk  in  1  clock; all state on posedge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU write-back request
- alu_reg  in  4  ALU destination register
- alu_data  in  32  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  memory write-back request
- mem_reg  in  4  memory destination register
- mem_data  in  32  load data
- mem_ready  out  1  memory request accepted this cycle
- reserve_valid  in  1  decode claims a destination register
- reserve_reg  in  4  claimed register
- src1_sel, src2_sel  in  4 each  decode source selectors
- hazard  out  1  a source has a pending write
- regwBoolean  out  1  register-file write enable (registered)
- rwselector  out  4  write selector (registered)
- rwdata  out  32  write data (registered)
- busy_mask  out  15  bit i set when r_i has a pending write
- err_pc_write  out  1  sticky: write-back to r15 attempted
- err_count  out  1  sticky: counter overflow or underflow

## Operation
- Transfer occurs when valid & ready on a port. At most one transfer per cycle.
- Arbitration is two-way round-robin.
  - If only one port is valid, that port is granted.
  - If both are valid, the port not granted last is granted.
  - After reset, the last-grant pointer is ALU, so MEM wins the first tie.
  - The pointer updates only on an actual transfer.
- ready is combinational from both valids and the pointer. Requesters must not make valid depend on ready.
- Granted write to r0..r14: on the next posedge, regwBoolean=1 and rwselector/rwdata take the granted reg/data. With no transfer, regwBoolean=0; selector and data hold their previous values.
- Granted write to r15: accepted (ready=1) but dropped. regwBoolean=0, err_pc_write sets and holds until reset.
- Scoreboard: one CNT_W-bit counter per r0..r14.
  - reserve_valid with reg≠15 increments the counter.
  - A transfer to that reg decrements it.
  - Both in the same cycle on the same reg: counter unchanged.
  - reserve_reg=15 is ignored.
  - Increment at max: counter saturates and err_count sets.
  - Decrement at 0: counter stays 0, err_count sets, and the write is still performed.
- busy_mask[i] = (cnt[i]≠0).
- hazard = (src1_sel≠15 & busy_mask[src1_sel]) | (src2_sel≠15 & busy_mask[src2_sel]). It is combinational from registered state only.

## Timing
- Request to register-file write enable: 1 cycle (transfer at edge N, regwBoolean high during cycle N+1). The register file writes on the negedge inside that cycle.
- A busy bit clears at the edge ending the transfer cycle, i.e. it is low during the cycle regwBoolean is high for that register. The negedge write precedes next-cycle reads, so no forwarding is needed.
- A reserve at edge N is visible in busy_mask/hazard during cycle N+1.
- Reset (asynchronous, any time, including mid-transfer):
  - regwBoolean=0, rwselector=0, rwdata=0
  - all counters 0, busy_mask=0, hazard=0
  - pointer=ALU, both err flags 0
  - an in-flight granted request is lost
- ready outputs are 0 while rst is high.

## Structure
- Package regfile_pkg: REG_PC=4'hF, NUM_REGS, typedef reg_idx_t (logic [3:0]), enum wb_src_t {WB_ALU, WB_MEM}, typedef wb_cmd_t struct {reg_idx_t sel; logic [31:0] data}.
- Sub-module rr_arbiter2: two requests plus a registered last-grant pointer in, one-hot grant out. It is reusable for other shared ports.
- Top level: grant mux, output register, scoreboard counter array, hazard logic, error flags.

## Test plan
- Reset, then alu_valid with alu_reg=3, alu_data=0x1234 -> alu_ready=1; next cycle regwBoolean=1, rwselector=3, rwdata=0x1234.
- alu_valid and mem_valid both held 3 cycles -> grants MEM, ALU, MEM; exactly one ready per cycle.
- Reserve r5 twice, then one write to r5 -> busy_mask[5] stays 1. A second write clears it; hazard with src1_sel=5 goes 1, 1, 0.
- mem_reg=15 write-back -> mem_ready=1, regwBoolean stays 0, err_pc_write=1 and held.
- Reserve r7 four times -> counter saturates at 3, err_count=1. src2_sel=15 never raises hazard.
- Assert rst mid-cycle with busy_mask=0x0021 and a transfer pending -> all outputs 0 immediately; no write occurs after release.
